// File: rtl/cc_tag_lookup.sv
// Tag-lookup stage of the cache controller.
// Each accepted read request is looked up in the tag array. It is then routed
// either to the hit path (hit-flag FIFO push plus data-array read) or to the
// miss path (miss-address and miss-request FIFO pushes). This stage also owns
// the tag-array write port used by line fills.
//
// Pipeline:
//   S0 (T)   : tag SRAM read issued combinationally from the decoded index.
//   S1 (T+1) : SRAM data returns. Colliding fills are forwarded. Hit is resolved.
//   S2 (T+2) : all FIFO pushes, the data read and the counters come from registers.
//
// Push semantics: there is no ready/backpressure anywhere in this block. A
// *_wren_o pulse is a single-cycle push that the consumer must accept. Upstream
// gating on FIFO almost-full guarantees room for the two in-flight lookups.
module cc_tag_lookup #(
  parameter int TAG_W = 17,
  parameter int IDX_W = 9,
  parameter int OFS_W = 6
) (
  input  logic                         clk,
  input  logic                         rst_n,
  // request from the read-address decoder
  input  logic                         hs_pulse_i,
  input  logic [TAG_W-1:0]             tag_i,
  input  logic [IDX_W-1:0]             index_i,
  input  logic [OFS_W-1:0]             offset_i,
  // tag SRAM read port
  output logic                         tag_rden_o,
  output logic [IDX_W-1:0]             tag_raddr_o,
  input  logic [TAG_W:0]               tag_rdata_i,
  // line fill and tag SRAM write port
  input  logic                         fill_wren_i,
  input  logic [IDX_W-1:0]             fill_index_i,
  input  logic [TAG_W-1:0]             fill_tag_i,
  output logic                         tag_wren_o,
  output logic [IDX_W-1:0]             tag_waddr_o,
  output logic [TAG_W:0]               tag_wdata_o,
  // hit path
  output logic                         hit_flag_fifo_wren_o,
  output logic [OFS_W:0]               hit_flag_fifo_wdata_o,
  output logic                         data_rden_o,
  output logic [IDX_W-1:0]             data_raddr_o,
  // miss path
  output logic                         miss_addr_fifo_wren_o,
  output logic [TAG_W+IDX_W+OFS_W-1:0] miss_addr_fifo_wdata_o,
  output logic                         miss_req_fifo_wren_o,
  output logic [TAG_W+IDX_W-1:0]       miss_req_fifo_wdata_o,
  // statistics
  output logic [31:0]                  hit_cnt_o,
  output logic [31:0]                  miss_cnt_o
);

  // S1 request registers
  logic             s1_vld;
  logic [TAG_W-1:0] s1_tag;
  logic [IDX_W-1:0] s1_index;
  logic [OFS_W-1:0] s1_offset;

  // Fill seen in the previous cycle. The SRAM returns old data when a write
  // and a read hit the same address together, so this register covers that case.
  logic             fq_vld;
  logic [IDX_W-1:0] fq_index;
  logic [TAG_W-1:0] fq_tag;

  // S1 effective entry and lookup result
  logic             entry_vld;
  logic [TAG_W-1:0] entry_tag;
  logic             s1_hit;
  logic             s1_miss;

  // S0: the SRAM read and the fill write are plain pass-throughs.
  always_comb begin
    tag_rden_o  = hs_pulse_i;
    tag_raddr_o = index_i;
    tag_wren_o  = fill_wren_i;
    tag_waddr_o = fill_index_i;
    tag_wdata_o = {1'b1, fill_tag_i};
  end

  // S0 -> S1: capture the request and the current fill.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      s1_vld    <= 1'b0;
      s1_tag    <= '0;
      s1_index  <= '0;
      s1_offset <= '0;
      fq_vld    <= 1'b0;
      fq_index  <= '0;
      fq_tag    <= '0;
    end else begin
      s1_vld    <= hs_pulse_i;
      s1_tag    <= tag_i;
      s1_index  <= index_i;
      s1_offset <= offset_i;
      fq_vld    <= fill_wren_i;
      fq_index  <= fill_index_i;
      fq_tag    <= fill_tag_i;
    end
  end

  // S1: pick the newest tag for s1_index (same-cycle fill, then last-cycle fill, then SRAM) and compare.
  always_comb begin
    entry_vld = tag_rdata_i[TAG_W];
    entry_tag = tag_rdata_i[TAG_W-1:0];
    if (fill_wren_i && (fill_index_i == s1_index)) begin
      entry_vld = 1'b1;
      entry_tag = fill_tag_i;
    end else if (fq_vld && (fq_index == s1_index)) begin
      entry_vld = 1'b1;
      entry_tag = fq_tag;
    end
    s1_hit  = s1_vld & entry_vld & (entry_tag == s1_tag);
    s1_miss = s1_vld & ~s1_hit;
  end

  // S1 -> S2: register every push, the data read and the statistics.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      hit_flag_fifo_wren_o   <= 1'b0;
      hit_flag_fifo_wdata_o  <= '0;
      data_rden_o            <= 1'b0;
      data_raddr_o           <= '0;
      miss_addr_fifo_wren_o  <= 1'b0;
      miss_addr_fifo_wdata_o <= '0;
      miss_req_fifo_wren_o   <= 1'b0;
      miss_req_fifo_wdata_o  <= '0;
      hit_cnt_o              <= '0;
      miss_cnt_o             <= '0;
    end else begin
      hit_flag_fifo_wren_o   <= s1_vld;
      hit_flag_fifo_wdata_o  <= {s1_hit, s1_offset};
      data_rden_o            <= s1_hit;
      data_raddr_o           <= s1_index;
      miss_addr_fifo_wren_o  <= s1_miss;
      miss_addr_fifo_wdata_o <= {s1_tag, s1_index, s1_offset};
      miss_req_fifo_wren_o   <= s1_miss;
      miss_req_fifo_wdata_o  <= {s1_tag, s1_index};
      if (s1_hit) begin
        hit_cnt_o <= hit_cnt_o + 32'd1;
      end
      if (s1_miss) begin
        miss_cnt_o <= miss_cnt_o + 32'd1;
      end
    end
  end

endmodule

// File: tb/tb_cc_tag_lookup.sv
// Self-checking bench for cc_tag_lookup.
// The bench emulates a 1R1W tag SRAM that returns old data on a same-address
// access. The reference model is an architectural tag table. A lookup issued
// in cycle T sees every fill made up to and including cycle T+1. Its push is
// expected in cycle T+2.
module tb_cc_tag_lookup;

  // ---------------- clock / reset ----------------
  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  // ---------------- DUT signals ----------------
  logic        hs_pulse_i = 1'b0;
  logic [16:0] tag_i = '0;
  logic [8:0]  index_i = '0;
  logic [5:0]  offset_i = '0;
  logic        tag_rden_o;
  logic [8:0]  tag_raddr_o;
  logic [17:0] tag_rdata_i;
  logic        fill_wren_i = 1'b0;
  logic [8:0]  fill_index_i = '0;
  logic [16:0] fill_tag_i = '0;
  logic        tag_wren_o;
  logic [8:0]  tag_waddr_o;
  logic [17:0] tag_wdata_o;
  logic        hit_flag_fifo_wren_o;
  logic [6:0]  hit_flag_fifo_wdata_o;
  logic        data_rden_o;
  logic [8:0]  data_raddr_o;
  logic        miss_addr_fifo_wren_o;
  logic [31:0] miss_addr_fifo_wdata_o;
  logic        miss_req_fifo_wren_o;
  logic [25:0] miss_req_fifo_wdata_o;
  logic [31:0] hit_cnt_o;
  logic [31:0] miss_cnt_o;

  cc_tag_lookup dut (
    .clk                    (clk),
    .rst_n                  (rst_n),
    .hs_pulse_i             (hs_pulse_i),
    .tag_i                  (tag_i),
    .index_i                (index_i),
    .offset_i               (offset_i),
    .tag_rden_o             (tag_rden_o),
    .tag_raddr_o            (tag_raddr_o),
    .tag_rdata_i            (tag_rdata_i),
    .fill_wren_i            (fill_wren_i),
    .fill_index_i           (fill_index_i),
    .fill_tag_i             (fill_tag_i),
    .tag_wren_o             (tag_wren_o),
    .tag_waddr_o            (tag_waddr_o),
    .tag_wdata_o            (tag_wdata_o),
    .hit_flag_fifo_wren_o   (hit_flag_fifo_wren_o),
    .hit_flag_fifo_wdata_o  (hit_flag_fifo_wdata_o),
    .data_rden_o            (data_rden_o),
    .data_raddr_o           (data_raddr_o),
    .miss_addr_fifo_wren_o  (miss_addr_fifo_wren_o),
    .miss_addr_fifo_wdata_o (miss_addr_fifo_wdata_o),
    .miss_req_fifo_wren_o   (miss_req_fifo_wren_o),
    .miss_req_fifo_wdata_o  (miss_req_fifo_wdata_o),
    .hit_cnt_o              (hit_cnt_o),
    .miss_cnt_o             (miss_cnt_o)
  );

  // ---------------- tag SRAM emulation (old data on collision) ----------------
  logic [17:0] mem [512] = '{default: '0};
  logic [17:0] sram_rdata;
  logic        poke_en = 1'b0;
  logic [8:0]  poke_idx = '0;
  logic [17:0] poke_val = '0;

  always @(posedge clk) begin
    if (tag_rden_o) sram_rdata <= mem[tag_raddr_o];
    else            sram_rdata <= 18'($urandom);
    if (poke_en)         mem[poke_idx]    <= poke_val;
    else if (tag_wren_o) mem[tag_waddr_o] <= tag_wdata_o;
  end
  assign tag_rdata_i = sram_rdata;

  // ---------------- reference model / scoreboard ----------------
  logic        ref_valid [512] = '{default: 1'b0};
  logic [16:0] ref_tag   [512] = '{default: '0};
  // entry = {due_cycle[31:0], hit, addr[31:0]}
  logic [64:0] exp_q[$];
  logic        pend_vld = 1'b0;
  logic [31:0] pend_addr = '0;
  int          cyc = 0;
  int          m_hit = 0;
  int          m_miss = 0;
  int          n_checks = 0;
  int          n_fail = 0;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  // Compare the outputs of the current cycle against the scoreboard.
  task automatic check_outputs();
    logic [64:0] e;
    logic        h;
    logic [31:0] a;
    if (hit_flag_fifo_wren_o) begin
      if (exp_q.size() == 0) begin
        check("unexpected_push", 64'(hit_flag_fifo_wren_o), 64'd0);
      end else begin
        e = exp_q.pop_front();
        h = e[32];
        a = e[31:0];
        check("push_cycle", 64'(cyc), 64'(e[64:33]));
        check("hit_flag_wdata", 64'(hit_flag_fifo_wdata_o), 64'({h, a[5:0]}));
        check("data_rden", 64'(data_rden_o), 64'(h));
        check("miss_addr_wren", 64'(miss_addr_fifo_wren_o), 64'(!h));
        check("miss_req_wren", 64'(miss_req_fifo_wren_o), 64'(!h));
        if (h) begin
          check("data_raddr", 64'(data_raddr_o), 64'(a[14:6]));
          m_hit++;
        end else begin
          check("miss_addr_wdata", 64'(miss_addr_fifo_wdata_o), 64'(a));
          check("miss_req_wdata", 64'(miss_req_fifo_wdata_o), 64'(a[31:6]));
          m_miss++;
        end
      end
    end else if (exp_q.size() > 0 && int'(exp_q[0][64:33]) <= cyc) begin
      check("missing_push", 64'(hit_flag_fifo_wren_o), 64'd1);
      void'(exp_q.pop_front());
    end else begin
      check("idle_quiet", 64'({data_rden_o, miss_addr_fifo_wren_o, miss_req_fifo_wren_o}), 64'd0);
    end
    check("hit_cnt", 64'(hit_cnt_o), 64'(m_hit));
    check("miss_cnt", 64'(miss_cnt_o), 64'(m_miss));
  endtask

  // ---------------- driver ----------------
  // One call is one clock cycle: check this cycle's outputs, drive the inputs, update the model.
  task automatic step(input logic hs, input logic [31:0] addr,
                      input logic fw, input logic [8:0] fidx, input logic [16:0] ftag);
    logic h;
    @(negedge clk);
    check_outputs();
    hs_pulse_i   = hs;
    tag_i        = addr[31:15];
    index_i      = addr[14:6];
    offset_i     = addr[5:0];
    fill_wren_i  = fw;
    fill_index_i = fidx;
    fill_tag_i   = ftag;
    #1;
    check("tag_rden", 64'(tag_rden_o), 64'(hs));
    if (hs) check("tag_raddr", 64'(tag_raddr_o), 64'(addr[14:6]));
    check("tag_wren", 64'(tag_wren_o), 64'(fw));
    if (fw) begin
      check("tag_waddr", 64'(tag_waddr_o), 64'(fidx));
      check("tag_wdata", 64'(tag_wdata_o), 64'({1'b1, ftag}));
    end
    // A fill in this cycle is visible to the lookup issued one cycle earlier.
    if (fw) begin
      ref_valid[fidx] = 1'b1;
      ref_tag[fidx]   = ftag;
    end
    if (pend_vld) begin
      h = ref_valid[pend_addr[14:6]] && (ref_tag[pend_addr[14:6]] == pend_addr[31:15]);
      exp_q.push_back({32'(cyc + 1), h, pend_addr});
    end
    pend_vld  = hs;
    pend_addr = addr;
    cyc++;
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) step(1'b0, 32'd0, 1'b0, 9'd0, 17'd0);
  endtask

  task automatic lookup(input logic [31:0] addr);
    step(1'b1, addr, 1'b0, 9'd0, 17'd0);
  endtask

  // Write an SRAM entry directly (lets the bench plant invalid or stale entries).
  task automatic poke(input logic [8:0] idx, input logic [17:0] val);
    poke_en  = 1'b1;
    poke_idx = idx;
    poke_val = val;
    ref_valid[idx] = val[17];
    ref_tag[idx]   = val[16:0];
    idle(1);
    poke_en = 1'b0;
  endtask

  function automatic logic [16:0] pick_tag();
    case ($urandom_range(0, 3))
      0:       return 17'h00000;
      1:       return 17'h00001;
      2:       return 17'h10000;
      default: return 17'h10001;
    endcase
  endfunction

  // ---------------- test sequence ----------------
  localparam logic [31:0] ADDR_A    = 32'h0001_2345;            // tag 2, index 0x08D, offset 0x05
  localparam logic [31:0] ADDR_A_B16 = {17'h10002, 9'h08D, 6'h05};
  localparam logic [31:0] ADDR_MISS = {17'h1FFFF, 9'h08D, 6'h3F};
  localparam logic [31:0] ADDR_F    = {17'h00003, 9'h010, 6'h0A};
  localparam logic [31:0] ADDR_INV  = {17'h00005, 9'h020, 6'h11};

  initial begin
    logic [31:0] h0;
    logic [31:0] m0;

    // reset values
    idle(3);
    check("rst_hit_flag_wren", 64'(hit_flag_fifo_wren_o), 64'd0);
    check("rst_hit_flag_wdata", 64'(hit_flag_fifo_wdata_o), 64'd0);
    check("rst_data_rden", 64'(data_rden_o), 64'd0);
    check("rst_data_raddr", 64'(data_raddr_o), 64'd0);
    check("rst_miss_addr_wren", 64'(miss_addr_fifo_wren_o), 64'd0);
    check("rst_miss_addr_wdata", 64'(miss_addr_fifo_wdata_o), 64'd0);
    check("rst_miss_req_wren", 64'(miss_req_fifo_wren_o), 64'd0);
    check("rst_miss_req_wdata", 64'(miss_req_fifo_wdata_o), 64'd0);
    check("rst_hit_cnt", 64'(hit_cnt_o), 64'd0);
    check("rst_miss_cnt", 64'(miss_cnt_o), 64'd0);
    rst_n = 1'b1;
    idle(2);

    // cold miss
    lookup(ADDR_A);
    idle(2);
    check("cold_miss_addr", 64'(miss_addr_fifo_wdata_o), 64'h0001_2345);
    check("cold_miss_req", 64'(miss_req_fifo_wdata_o), 64'h000_048D);
    check("cold_hit_flag", 64'(hit_flag_fifo_wdata_o), 64'h05);
    check("cold_miss_cnt", 64'(miss_cnt_o), 64'd1);

    // fill 0x08D with tag 2, then hit
    step(1'b0, 32'd0, 1'b1, 9'h08D, 17'h00002);
    idle(1);
    lookup(ADDR_A);
    idle(2);
    check("hit_data_rden", 64'(data_rden_o), 64'd1);
    check("hit_data_raddr", 64'(data_raddr_o), 64'h08D);
    check("hit_flag", 64'(hit_flag_fifo_wdata_o), 64'h45);
    check("hit_cnt_1", 64'(hit_cnt_o), 64'd1);
    check("hit_no_miss_push", 64'({miss_addr_fifo_wren_o, miss_req_fifo_wren_o}), 64'd0);

    // tag differs by bit 16 -> miss; invalid entry with matching tag bits -> miss
    lookup(ADDR_A_B16);
    idle(2);
    check("b16_is_miss", 64'(miss_addr_fifo_wren_o), 64'd1);
    poke(9'h020, {1'b0, 17'h00005});
    lookup(ADDR_INV);
    idle(2);
    check("invalid_is_miss", 64'(miss_req_fifo_wren_o), 64'd1);

    // fill forwarding: stale entry tag 7 at index 0x10, request tag 3
    poke(9'h010, {1'b1, 17'h00007});
    lookup(ADDR_F);
    step(1'b0, 32'd0, 1'b1, 9'h010, 17'h00003);          // fill at T+1
    idle(1);
    check("fwd_t1_hit", 64'(data_rden_o), 64'd1);
    poke(9'h010, {1'b1, 17'h00007});
    step(1'b1, ADDR_F, 1'b1, 9'h010, 17'h00003);         // fill at T
    idle(2);
    check("fwd_t0_hit", 64'(data_rden_o), 64'd1);
    poke(9'h010, {1'b1, 17'h00007});
    lookup(ADDR_F);
    idle(1);
    step(1'b0, 32'd0, 1'b1, 9'h010, 17'h00003);          // fill at T+2
    check("fwd_t2_miss", 64'(hit_flag_fifo_wdata_o[6]), 64'd0);
    check("fwd_t2_miss_push", 64'(miss_addr_fifo_wren_o), 64'd1);
    idle(1);

    // fill to a different index at T+1 does not affect the lookup
    poke(9'h010, {1'b1, 17'h00007});
    lookup(ADDR_F);
    step(1'b0, 32'd0, 1'b1, 9'h011, 17'h00003);
    idle(1);
    check("fwd_other_idx_miss", 64'(miss_req_fifo_wren_o), 64'd1);

    // streaming: 8 back-to-back pulses alternating hit/miss
    h0 = hit_cnt_o;
    m0 = miss_cnt_o;
    for (int i = 0; i < 8; i++) lookup((i % 2 == 0) ? ADDR_A : ADDR_MISS);
    idle(3);
    check("stream_hits", 64'(hit_cnt_o - h0), 64'd4);
    check("stream_misses", 64'(miss_cnt_o - m0), 64'd4);

    // randomized traffic over a small index/tag set so hits and collisions are frequent
    for (int i = 0; i < 400; i++) begin
      logic [31:0] a;
      a = {pick_tag(), 9'h100 + 9'($urandom_range(0, 7)), 6'($urandom)};
      step($urandom_range(0, 9) < 7, a, $urandom_range(0, 3) == 0,
           9'h100 + 9'($urandom_range(0, 7)), pick_tag());
    end
    idle(3);

    // reset mid-flight: pulses at T and T+1, reset during T+1
    lookup(ADDR_A);
    lookup(ADDR_MISS);
    rst_n = 1'b0;
    exp_q.delete();
    pend_vld = 1'b0;
    m_hit  = 0;
    m_miss = 0;
    idle(2);
    rst_n = 1'b1;
    idle(3);
    check("midrst_hit_cnt", 64'(hit_cnt_o), 64'd0);
    check("midrst_miss_cnt", 64'(miss_cnt_o), 64'd0);

    check("scoreboard_drained", 64'(exp_q.size()), 64'd0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/cc_tag_lookup.md
# cc_tag_lookup

Tag-lookup stage of the cache controller, directly downstream of the read-address decoder. On every accepted AR handshake pulse it reads the tag array at the decoded index and compares the stored tag against the request tag. It then routes the request to the hit path (hit-flag FIFO plus data-array read) or the miss path (miss-address and miss-request FIFOs). It also owns the tag-array write port for line fills, forwards fills that collide with in-flight lookups, and keeps hit/miss statistics counters.

## Interface
Parameters:
- TAG_W, 17, tag width
- IDX_W, 9, index width (512 sets)
- OFS_W, 6, byte offset width (64 B line)

Ports:
- clk  in  1  clock
- rst_n  in  1  reset; one clock, asynchronous assert, active-low
- hs_pulse_i  in  1  AR handshake accepted this cycle
- tag_i / index_i / offset_i  in  17/9/6  decoded request fields, valid with hs_pulse_i
- tag_rden_o  out  1  tag SRAM read enable
- tag_raddr_o  out  9  tag SRAM read address
- tag_rdata_i  in  18  {valid, tag}; valid one cycle after tag_rden_o
- fill_wren_i  in  1  line fill completes this cycle
- fill_index_i / fill_tag_i  in  9/17  fill target
- tag_wren_o  out  1  tag SRAM write enable
- tag_waddr_o  out  9  tag SRAM write address
- tag_wdata_o  out  18  tag SRAM write data
- hit_flag_fifo_wren_o  out  1  push to hit-flag FIFO
- hit_flag_fifo_wdata_o  out  7  {hit, offset}
- data_rden_o  out  1  data SRAM read enable (hits only)
- data_raddr_o  out  9  data SRAM line index
- miss_addr_fifo_wren_o  out  1  push to miss-address FIFO
- miss_addr_fifo_wdata_o  out  32  full request address
- miss_req_fifo_wren_o  out  1  push to miss-request FIFO
- miss_req_fifo_wdata_o  out  26  line address {tag, index}
- hit_cnt_o / miss_cnt_o  out  32/32  statistics counters

## Operation
- S0 (cycle T, combinational): tag_rden_o = hs_pulse_i and tag_raddr_o = index_i. Register tag/index/offset and s1_vld <= hs_pulse_i.
- S1 (cycle T+1): form the effective entry:
  - if fill_wren_i=1 and fill_index_i==s1_index, use {1, fill_tag_i};
  - else if the fill registered at T targeted s1_index, use {1, that tag};
  - else use tag_rdata_i.
  - hit = s1_vld & entry.valid & (entry.tag == s1_tag). Register hit, miss = s1_vld & ~hit, and the fields into S2.
- S2 (cycle T+2), all outputs driven from registers:
  - every request: hit_flag_fifo_wren_o=1 with wdata={hit, offset}.
  - hit: data_rden_o=1, data_raddr_o=index, hit_cnt_o+1.
  - miss: miss_addr_fifo_wren_o=1 with {tag,index,offset}; miss_req_fifo_wren_o=1 with {tag,index}; miss_cnt_o+1.
- Fill path is combinational pass-through: tag_wren_o=fill_wren_i, tag_waddr_o=fill_index_i, tag_wdata_o={1,fill_tag_i}. The SRAM is 1R1W and returns old data on same-address read/write; the forwarding above covers this.
- Counters wrap modulo 2^32.
- No backpressure input. Upstream gating by FIFO almost-full guarantees space, and every almost-full threshold leaves at least 2 free entries for the in-flight pipeline.

## Timing
- Lookup latency is fixed: hs_pulse_i at T gives FIFO pushes at T+2.
- Throughput is one lookup per cycle. Back-to-back pulses produce back-to-back pushes, in order.
- Reset values are 0 for every registered output: all wren/rden, all wdata/raddr, both counters, s1_vld, s2_vld, the fill register. Combinational outputs follow their inputs.
- Reset asserted mid-operation: in-flight lookups are dropped without any FIFO push, and the counters clear.
- A fill at T+1 to the index of the lookup in S1 forces a hit when the tags match. A fill at T+2 or later does not affect that lookup.
- A fill at T+1 to a different index does not affect the lookup.
- tag_rdata_i is sampled only when s1_vld=1.

## Test plan
- Cold miss: reset, then hs at addr 0x0001_2345 with tag_rdata_i=0 -> at T+2, miss_addr wdata 0x0001_2345, miss_req wdata 0x000048D, hit_flag wdata {0,0x05}, miss_cnt=1.
- Hit: tag_rdata_i={1,0x00002} for index 0x08D on the same address -> data_rden_o=1 with raddr 0x08D, hit_flag wdata {1,0x05}, hit_cnt=1, no miss pushes.
- Tag mismatch: valid entry, tag differs by bit 16 -> miss path. Invalid entry with matching tag bits -> miss.
- Fill forwarding: hs at T to index 0x10, stale rdata, fill_wren_i at T+1 with index 0x10 and the request tag -> hit. Repeat with the fill at T (registered bypass) -> hit. Repeat with the fill at T+2 -> miss.
- Streaming: 8 consecutive pulses alternating hit/miss -> 8 in-order hit_flag pushes at T+2..T+9, counters 4/4.
- Reset mid-flight: pulses at T and T+1, rst_n low at T+1 -> no pushes and both counters 0 after release.
